dcim_sram_ctrl: RTL and testbench

- Single-port initiator that drives the 16x8 6T SRAM macro of the DCIM array from a valid/ready request stream.
- Converts write/read requests into the macro's active-low chip-enable / write-enable cycle and returns read data on a valid/ready response stream.
- Sits between the DCIM weight loader / host port and the SRAM macro instance.

---
 rtl/dcim_sram_pkg.sv | 28 ++
 rtl/dcim_sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_dcim_sram_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcim_sram_pkg.sv
// -----------------------------------------------------------------------------
// dcim_sram_pkg
//
// Shared definitions for the DCIM SRAM initiator (dcim_sram_ctrl):
//   - state_t       : controller FSM states
//   - AW_DEFAULT    : default word-address width (16-word macro)
//   - DW_DEFAULT    : default data word width
//   - CE_IDLE / CE_ACTIVE : macro chip-enable levels (active-low)
//   - WE_READ / WE_WRITE  : macro write-enable levels (active-low)
// -----------------------------------------------------------------------------
package dcim_sram_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,  // power-up zero sweep (optional build)
        IDLE   = 2'd1,  // waiting for a request
        ACCESS = 2'd2,  // the single macro access cycle
        RESP   = 2'd3   // holding read data until consumed
    } state_t;

    localparam int AW_DEFAULT = 4;
    localparam int DW_DEFAULT = 8;

    localparam logic CE_IDLE   = 1'b1;
    localparam logic CE_ACTIVE = 1'b0;
    localparam logic WE_READ   = 1'b1;
    localparam logic WE_WRITE  = 1'b0;

endpackage : dcim_sram_pkg

// File: rtl/dcim_sram_ctrl.sv
// -----------------------------------------------------------------------------
// dcim_sram_ctrl
//
// Single-port initiator for the DCIM array's 6T SRAM macro. Turns a
// valid/ready request stream (write or read) into one active-low
// chip-enable / write-enable macro cycle, and returns read data on a
// valid/ready response stream. Writes produce no response.
//
// Optional build macro: DCIM_SRAM_CTRL_INIT_EN
//   When defined, reset enters INIT and the controller writes zero to every
//   macro word (address 0..DEPTH-1, one per cycle) before accepting requests.
//   When undefined, reset enters IDLE and macro contents are left untouched.
//
// Ports:
//   clk        in   1   clock, all logic on posedge
//   rst_n      in   1   synchronous active-low reset
//   req_valid  in   1   request valid
//   req_ready  out  1   request accepted on req_valid && req_ready at posedge
//   req_write  in   1   1 = write, 0 = read
//   req_addr   in   AW  word address
//   req_wdata  in   DW  write data (ignored for reads)
//   rsp_valid  out  1   read data valid
//   rsp_ready  in   1   consumer accepts the response
//   rsp_rdata  out  DW  read data
//   sram_ce_n  out  1   macro chip enable, 0 = access
//   sram_we_n  out  1   macro write enable, 0 = write, 1 = read
//   sram_addr  out  AW  macro address (also the INIT sweep counter)
//   sram_wd    out  DW  macro write data
//   sram_rd    in   DW  macro read data, valid from mid-cycle of a read
//   busy       out  1   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module dcim_sram_ctrl
    import dcim_sram_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_ce_n,
    output logic          sram_we_n,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wd,
    input  logic [DW-1:0] sram_rd,
    output logic          busy
);

`ifdef DCIM_SRAM_CTRL_INIT_EN
    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam state_t        RST_STATE = INIT;
`else
    localparam state_t        RST_STATE = IDLE;
`endif

    state_t state;

    // Handshake/status flags are pure decodes of the state register, so no
    // combinational path runs from req_* to any output.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // NOTE: one clocked block owns all state and every macro-side output, and
    // assigns them with non-blocking <= so every register updates from the
    // same pre-edge values. The reset is synchronous: it is just the first
    // branch inside the posedge block, not part of the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            sram_ce_n <= CE_IDLE;
            sram_we_n <= WE_READ;
            sram_addr <= '0;
            sram_wd   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
`ifdef DCIM_SRAM_CTRL_INIT_EN
                // ce_n still high means we are on the first cycle out of
                // reset: start the sweep at address 0. Afterwards ce_n/we_n
                // stay low and sram_addr steps once per write cycle.
                INIT: begin
                    sram_wd <= '0;
                    if (sram_ce_n == CE_IDLE) begin
                        sram_ce_n <= CE_ACTIVE;
                        sram_we_n <= WE_WRITE;
                        sram_addr <= '0;
                    end else if (sram_addr == LAST_ADDR) begin
                        sram_ce_n <= CE_IDLE;
                        sram_we_n <= WE_READ;
                        state     <= IDLE;
                    end else begin
                        sram_addr <= sram_addr + 1'b1;
                    end
                end
`endif
                IDLE: begin
                    if (req_valid) begin
                        sram_addr <= req_addr;
                        sram_wd   <= req_wdata;
                        sram_ce_n <= CE_ACTIVE;
                        sram_we_n <= req_write ? WE_WRITE : WE_READ;
                        state     <= ACCESS;
                    end
                end

                // The macro commits a write at this edge; for a read its data
                // has been on sram_rd since the mid-cycle negedge.
                ACCESS: begin
                    sram_ce_n <= CE_IDLE;
                    sram_we_n <= WE_READ;
                    if (sram_we_n == WE_READ) begin
                        rsp_rdata <= sram_rd;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state     <= IDLE;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : dcim_sram_ctrl

// File: tb/tb_dcim_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcim_sram_ctrl
//
// Self-checking bench for dcim_sram_ctrl. Includes a behavioural 16x8 macro
// (write at posedge, read data driven at negedge), a directed vector table,
// hand-written multi-cycle sequences and a randomized phase scored against
// an array model of memory contents.
// -----------------------------------------------------------------------------
module tb_dcim_sram_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_ce_n;
    logic          sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wd;
    logic [DW-1:0] sram_rd;
    logic          busy;

    int tests_run = 0;
    int tests_failed = 0;

    dcim_sram_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_ce_n (sram_ce_n),
        .sram_we_n (sram_we_n),
        .sram_addr (sram_addr),
        .sram_wd   (sram_wd),
        .sram_rd   (sram_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro.
    logic [DW-1:0] macro_mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) macro_mem[sram_addr] <= sram_wd;
    end
    always @(negedge clk) begin
        if (!sram_ce_n && sram_we_n) sram_rd <= macro_mem[sram_addr];
    end

    // Expected memory contents, maintained from the requests issued.
    logic [DW-1:0] model_mem [DEPTH];
    bit            model_known [DEPTH];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
        int            stall;  // cycles rsp_ready held low on reads
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ce_n"}, sram_ce_n, 1);
        check({tag, "_we_n"}, sram_we_n, 1);
        check({tag, "_addr"}, sram_addr, 0);
        check({tag, "_wd"}, sram_wd, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
`ifdef DCIM_SRAM_CTRL_INIT_EN
        check({tag, "_busy"}, busy, 1);
        check({tag, "_req_ready"}, req_ready, 0);
`else
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 1);
`endif
    endtask

    // Called at a negedge after reset has been sampled.
    task automatic release_reset();
        rst_n = 1'b1;
`ifdef DCIM_SRAM_CTRL_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("init_ce_n", sram_ce_n, 0);
            check("init_we_n", sram_we_n, 0);
            check("init_addr", sram_addr, i);
            check("init_wd", sram_wd, 0);
            check("init_busy", busy, 1);
            check("init_req_ready", req_ready, 0);
        end
        @(negedge clk);
        check("init_done_ce_n", sram_ce_n, 1);
        check("init_done_req_ready", req_ready, 1);
        check("init_done_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b1;
        end
`endif
    endtask

    // Present a request at a negedge, wait (bounded) for acceptance, and
    // check the macro cycle. Returns at the negedge inside ACCESS.
    task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", {31'd0, req_ready}, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("acc_ce_n", sram_ce_n, 0);
        check("acc_we_n", sram_we_n, {31'd0, ~wr});
        check("acc_addr", sram_addr, a);
        if (wr) check("acc_wd", sram_wd, d);
        check("acc_req_ready", req_ready, 0);
        check("acc_busy", busy, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        send(1'b1, a, d);
        model_mem[a]   = d;
        model_known[a] = 1'b1;
        @(negedge clk);
        check("wr_done_ce_n", sram_ce_n, 1);
        check("wr_done_req_ready", req_ready, 1);
        check("wr_no_rsp", rsp_valid, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int stall);
        send(1'b0, a, '0);
        check("rd_lat_rsp_low", rsp_valid, 0);
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, exp);
        check("rd_resp_ce_n", sram_ce_n, 1);
        check("rd_resp_req_ready", req_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_rdata", rsp_rdata, exp);
            check("stall_req_ready", req_ready, 0);
            check("stall_ce_n", sram_ce_n, 1);
            check("stall_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rd_done_rsp_valid", rsp_valid, 0);
        check("rd_done_req_ready", req_ready, 1);
        check("rd_done_busy", busy, 0);
    endtask

    initial begin : stim
        int accepts;
        int j;
        logic [AW-1:0] ra;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        release_reset();

`ifdef DCIM_SRAM_CTRL_INIT_EN
        do_read(4'd9, 8'h00, 0);
`endif

        // Directed vectors.
        vecs[0] = '{wr: 1'b1, addr: 4'd3,  data: 8'hA5, stall: 0};
        vecs[1] = '{wr: 1'b0, addr: 4'd3,  data: 8'hA5, stall: 0};
        vecs[2] = '{wr: 1'b1, addr: 4'd0,  data: 8'h11, stall: 0};
        vecs[3] = '{wr: 1'b1, addr: 4'd15, data: 8'hEE, stall: 0};
        vecs[4] = '{wr: 1'b0, addr: 4'd15, data: 8'hEE, stall: 0};
        vecs[5] = '{wr: 1'b0, addr: 4'd0,  data: 8'h11, stall: 0};
        vecs[6] = '{wr: 1'b0, addr: 4'd3,  data: 8'hA5, stall: 5};
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].data, vecs[i].stall);
        end

        // Back-to-back writes with req_valid held high: one accept per 2 cycles.
        accepts   = 0;
        j         = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) begin
                req_addr  = AW'(4 + j);
                req_wdata = DW'(8'h40 + j);
                model_mem[4 + j]   = DW'(8'h40 + j);
                model_known[4 + j] = 1'b1;
                accepts++;
                j++;
            end
            @(negedge clk);
            check("b2b_ce_n", sram_ce_n, (i % 2 == 0) ? 0 : 1);
        end
        req_valid = 1'b0;
        check("b2b_accepts", accepts, 4);
        do_read(4'd6, 8'h42, 1);

        // Reset at the posedge that ends a read ACCESS.
        send(1'b0, 4'd3, '0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midrd");
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrd_no_rsp", rsp_valid, 0);
        end
        do_read(4'd4, model_mem[4], 0);

        // Randomized traffic against the memory model.
        for (int n = 0; n < 60; n++) begin
            ra = AW'($urandom_range(DEPTH - 1));
            if ($urandom_range(1) == 1 || !model_known[ra])
                do_write(ra, DW'($urandom));
            else
                do_read(ra, model_mem[ra], $urandom_range(3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_dcim_sram_ctrl
